mem_port_ctrl: RTL and testbench
================================

# mem_port_ctrl

- Command-driven initiator for one port of the team's dual-port synchronous RAM (load / oe / addr / data strobes, registered read, tri-state when oe is low).
- Accepts read, write and fill commands over a valid/ready handshake and drives the RAM port strobes.
- Absorbs the RAM's one-cycle registered read latency and returns exactly one response per command over a valid/ready handshake.
- Sits between the CPU control sequencer (or a loader) and RAM port A or B.

## Interface
- ADDR_WIDTH, 4, RAM address width; depth = 2^ADDR_WIDTH
- DATA_WIDTH, 8, RAM data width
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller accepts a command this cycle
- cmd_op  in  2  00 read, 01 write, 10 fill, 11 reserved
- cmd_addr  in  ADDR_WIDTH  target address (ignored for fill)
- cmd_wdata  in  DATA_WIDTH  write data / fill pattern
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_data  out  DATA_WIDTH  read data; 0 for write, fill, reserved
- rsp_err  out  1  1 only for reserved op
- mem_load  out  1  RAM write strobe
- mem_oe  out  1  RAM read strobe
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM registered read data (Z when not enabled)

## Operation
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch op/addr/wdata. Go to WR (01), RD_OE (00), FILL (10), or RESP with rsp_err=1 (11).
  - WR: mem_load=1 for exactly one cycle with the latched addr/data, then RESP.
  - RD_OE: mem_oe=1 for exactly one cycle, then RD_CAP.
  - RD_CAP: mem_oe=0; rsp_data captures mem_rdata at the closing edge; then RESP.
  - FILL: mem_load=1 every cycle; mem_addr counts 0 .. 2^ADDR_WIDTH-1 with mem_wdata=pattern. Leave after writing the top address (no wrap re-entry), then RESP.
  - RESP: rsp_valid=1 and rsp_data/rsp_err stable until rsp_ready is sampled high; return to IDLE at that edge.
- Single outstanding command. cmd_ready=0 in every state except IDLE; commands are never queued.
- mem_load and mem_oe are never asserted in the same cycle. Both are low in IDLE and RESP.
- All mem_* outputs are registered. mem_addr/mem_wdata hold their last value when no strobe is asserted.
- rsp_data is cleared to 0 on acceptance of any non-read command.
- Async reset (rst_n low), effective immediately, including mid-operation:
  - state=IDLE; mem_load=0, mem_oe=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, rsp_err=0, cmd_ready=0.
  - An aborted fill leaves RAM partially written; no response is issued for an aborted command.
- cmd_ready rises at the first rising clk edge after rst_n deasserts.

## Timing
- Edge 0 = the edge where cmd_valid&&cmd_ready is sampled.
- Write: mem_load high in cycle after edge 0; RAM written at edge 1; rsp_valid high from edge 2.
- Read: mem_oe high after edge 0; RAM registers data at edge 1; captured at edge 2; rsp_valid high from edge 3. Capture happens at the same edge the RAM output returns to Z, so it sees the valid value.
- Fill: mem_load high for 2^ADDR_WIDTH consecutive cycles starting after edge 0; rsp_valid high from edge 2^ADDR_WIDTH+1.
- Reserved op: rsp_valid high from edge 1.
- Next command accepted no earlier than the edge after the rsp handshake (one IDLE cycle minimum).
- rsp_ready held high continuously: back-to-back writes take 4 cycles each, reads 5.

## Test plan
- Reset: assert rst_n low mid-cycle -> all outputs 0 immediately. Release -> cmd_ready=1 after next edge.
- Write 0xA5 to addr 3, then read addr 3 -> write rsp_data=0, rsp_err=0 at edge 2. mem_oe high one cycle. Read rsp_data=0xA5 at edge 3.
- Fill 0x3C, then read addrs 0, 7, 15 -> mem_load high 16 consecutive cycles, addrs 0..15. Fill response at edge 17. All reads return 0x3C.
- Backpressure: read with rsp_ready low 5 cycles -> rsp_valid and rsp_data stable throughout. cmd_ready stays 0. Handshake on 6th cycle returns to IDLE.
- Reserved op 11 -> rsp_valid at edge 1, rsp_err=1, rsp_data=0, no mem_load/mem_oe activity.
- Reset during fill at addr 5 -> mem_load drops immediately. No response issued. Subsequent reads of addrs 0–4 return the pattern; addrs 5–15 keep their prior contents.

Source files
------------

// File: rtl/mem_port_ctrl.sv
// -----------------------------------------------------------------------------
// mem_port_ctrl
//
// Command-driven initiator for one port of the dual-port synchronous RAM.
// Takes read / write / fill commands over a valid/ready handshake, drives the
// RAM port strobes, absorbs the RAM's one-cycle registered read latency and
// returns exactly one response per accepted command over a valid/ready
// handshake. Only one command is ever outstanding.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   cmd_valid_i  command present
//   cmd_ready_o  controller accepts a command this cycle (IDLE only)
//   cmd_op_i     00 read, 01 write, 10 fill, 11 reserved
//   cmd_addr_i   target address (ignored for fill)
//   cmd_wdata_i  write data / fill pattern
//   rsp_valid_o  response present
//   rsp_ready_i  consumer takes response
//   rsp_data_o   read data; 0 for write, fill and reserved
//   rsp_err_o    1 only for the reserved op
//   mem_load_o   RAM write strobe
//   mem_oe_o     RAM read strobe
//   mem_addr_o   RAM address
//   mem_wdata_o  RAM write data
//   mem_rdata_i  RAM registered read data (Z when not enabled)
// -----------------------------------------------------------------------------
module mem_port_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [1:0]            cmd_op_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_data_o,
   output logic                  rsp_err_o,
   output logic                  mem_load_o,
   output logic                  mem_oe_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WR     = 3'd1,
      S_RD_OE  = 3'd2,
      S_RD_CAP = 3'd3,
      S_FILL   = 3'd4,
      S_RESP   = 3'd5
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                  state_q;
   logic                    cmd_ready_q;
   logic                    rsp_valid_q;
   logic [DATA_WIDTH-1:0]   rsp_data_q;
   logic                    rsp_err_q;
   logic                    mem_load_q;
   logic                    mem_oe_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic [DATA_WIDTH-1:0]   mem_wdata_q;

   // Controller FSM with every output held in a register.
   // Strobes are set on the transition into their state so they line up with
   // it; rsp_valid rises one cycle after RESP is entered, which gives the
   // write/read/fill/reserved response latencies of 2/3/2^N+1/1 edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= {DATA_WIDTH{1'b0}};
         rsp_err_q   <= 1'b0;
         mem_load_q  <= 1'b0;
         mem_oe_q    <= 1'b0;
         mem_addr_q  <= {ADDR_WIDTH{1'b0}};
         mem_wdata_q <= {DATA_WIDTH{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               // cmd_ready is registered, so it first rises one edge after reset release
               if (cmd_ready_q && cmd_valid_i) begin
                  cmd_ready_q <= 1'b0;
                  case (cmd_op_i)
                     2'b00: begin
                        state_q    <= S_RD_OE;
                        mem_oe_q   <= 1'b1;
                        mem_addr_q <= cmd_addr_i;
                        rsp_err_q  <= 1'b0;
                     end
                     2'b01: begin
                        state_q     <= S_WR;
                        mem_load_q  <= 1'b1;
                        mem_addr_q  <= cmd_addr_i;
                        mem_wdata_q <= cmd_wdata_i;
                        rsp_data_q  <= {DATA_WIDTH{1'b0}};
                        rsp_err_q   <= 1'b0;
                     end
                     2'b10: begin
                        state_q     <= S_FILL;
                        mem_load_q  <= 1'b1;
                        mem_addr_q  <= {ADDR_WIDTH{1'b0}};
                        mem_wdata_q <= cmd_wdata_i;
                        rsp_data_q  <= {DATA_WIDTH{1'b0}};
                        rsp_err_q   <= 1'b0;
                     end
                     default: begin
                        state_q    <= S_RESP;
                        rsp_data_q <= {DATA_WIDTH{1'b0}};
                        rsp_err_q  <= 1'b1;
                     end
                  endcase
               end else begin
                  cmd_ready_q <= 1'b1;
               end
            end
            S_WR: begin
               mem_load_q <= 1'b0;
               state_q    <= S_RESP;
            end
            S_RD_OE: begin
               mem_oe_q <= 1'b0;
               state_q  <= S_RD_CAP;
            end
            S_RD_CAP: begin
               // RAM output is still driven at this edge; it goes Z just after
               rsp_data_q <= mem_rdata_i;
               state_q    <= S_RESP;
            end
            S_FILL: begin
               // leave after the top address is written; the counter never wraps
               if (mem_addr_q == ADDR_MAX) begin
                  mem_load_q <= 1'b0;
                  state_q    <= S_RESP;
               end else begin
                  mem_addr_q <= mem_addr_q + ADDR_ONE;
               end
            end
            S_RESP: begin
               if (!rsp_valid_q) begin
                  rsp_valid_q <= 1'b1;
               end else if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end else begin
                  rsp_valid_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               cmd_ready_q <= 1'b0;
               rsp_valid_q <= 1'b0;
               mem_load_q  <= 1'b0;
               mem_oe_q    <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_err_o   = rsp_err_q;
   assign mem_load_o  = mem_load_q;
   assign mem_oe_o    = mem_oe_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for mem_port_ctrl: a directed vector table, hand-written reset
// sequences and randomized commands checked against an array-based model of
// the RAM contents and the per-command latencies.
// -----------------------------------------------------------------------------
module tb_mem_port_ctrl;
   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic [1:0]    cmd_op_i;
   logic [AW-1:0] cmd_addr_i;
   logic [DW-1:0] cmd_wdata_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [DW-1:0] rsp_data_o;
   logic          rsp_err_o;
   logic          mem_load_o;
   logic          mem_oe_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   wire  [DW-1:0] mem_rdata_i;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   // free-running edge counter used to measure command spacing
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
      .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
      .mem_load_o(mem_load_o), .mem_oe_o(mem_oe_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i)
   );

   // ---------------- RAM port model (registered read, Z when idle) ----------
   logic [DW-1:0] ram [DEPTH];
   logic [DW-1:0] ram_q;
   logic          ram_en;
   logic          ram_init;

   function automatic logic [DW-1:0] init_val(input int i);
      return DW'(i * 13 + 5);
   endfunction

   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
         ram_en <= 1'b0;
      end else begin
         if (mem_load_o) ram[mem_addr_o] <= mem_wdata_o;
         if (mem_oe_o) ram_q <= ram[mem_addr_o];
         ram_en <= mem_oe_o;
      end
   end
   assign mem_rdata_i = ram_en ? ram_q : {DW{1'bz}};

   // ---------------- reference model -----------------------------------------
   logic [DW-1:0] ref_mem [DEPTH];

   task automatic model(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        output logic [DW-1:0] d, output logic e, output int lat,
                        output int loads, output int oes);
      d = '0; e = 1'b0; loads = 0; oes = 0; lat = 0;
      case (op)
         2'b00: begin d = ref_mem[addr]; lat = 3; oes = 1; end
         2'b01: begin ref_mem[addr] = wd; lat = 2; loads = 1; end
         2'b10: begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = wd;
            lat = DEPTH + 1; loads = DEPTH;
         end
         default: begin e = 1'b1; lat = 1; end
      endcase
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_cmd_ready"}, 32'(cmd_ready_o), 0);
      chk({nm, "_rsp_valid"}, 32'(rsp_valid_o), 0);
      chk({nm, "_rsp_data"},  32'(rsp_data_o),  0);
      chk({nm, "_rsp_err"},   32'(rsp_err_o),   0);
      chk({nm, "_mem_load"},  32'(mem_load_o),  0);
      chk({nm, "_mem_oe"},    32'(mem_oe_o),    0);
      chk({nm, "_mem_addr"},  32'(mem_addr_o),  0);
      chk({nm, "_mem_wdata"}, 32'(mem_wdata_o), 0);
   endtask

   // Issue one command (entered and left at a negedge), observe the port.
   task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int hold, output logic [DW-1:0] data, output logic err,
                          output int lat, output int loads, output int oes, output int acc);
      int n;
      logic [DW-1:0] d0;
      logic e0;
      loads = 0; oes = 0; lat = 0; data = '0; err = 1'b0; acc = 0;
      n = 0;
      while (cmd_ready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("cmd_ready_wait", 32'(cmd_ready_o), 1);
      if (cmd_ready_o !== 1'b1) return;
      cmd_valid_i = 1'b1; cmd_op_i = op; cmd_addr_i = addr; cmd_wdata_i = wd;
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      cmd_valid_i = 1'b0;
      cmd_op_i = 2'($urandom); cmd_addr_i = AW'($urandom); cmd_wdata_i = DW'($urandom);
      n = 0;
      while (rsp_valid_o !== 1'b1 && n < 100) begin
         chk("strobe_excl", 32'(mem_load_o & mem_oe_o), 0);
         chk("busy_ready", 32'(cmd_ready_o), 0);
         if (mem_load_o) begin
            chk("load_addr", 32'(mem_addr_o), (op == 2'b10) ? 32'(loads) : 32'(addr));
            chk("load_data", 32'(mem_wdata_o), 32'(wd));
            loads++;
         end
         if (mem_oe_o) begin
            chk("oe_addr", 32'(mem_addr_o), 32'(addr));
            oes++;
         end
         @(negedge clk);
         n++;
      end
      lat = n;
      chk("rsp_arrived", 32'(rsp_valid_o), 1);
      if (rsp_valid_o !== 1'b1) return;
      d0 = rsp_data_o; e0 = rsp_err_o;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("bp_valid",  32'(rsp_valid_o), 1);
         chk("bp_data",   32'(rsp_data_o), 32'(d0));
         chk("bp_err",    32'(rsp_err_o), 32'(e0));
         chk("bp_ready",  32'(cmd_ready_o), 0);
         chk("bp_strobe", 32'(mem_load_o | mem_oe_o), 0);
      end
      rsp_ready_i = 1'b1;
      @(negedge clk);
      rsp_ready_i = 1'b0;
      chk("post_valid", 32'(rsp_valid_o), 0);
      chk("post_ready", 32'(cmd_ready_o), 1);
      data = d0; err = e0;
   endtask

   // Run a command and compare against the model.
   task automatic exec(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input int hold, input string nm, output logic [DW-1:0] d,
                       output logic e, output int l, output int acc);
      logic [DW-1:0] ed;
      logic ee;
      int el, elo, eoe, lo, oe;
      model(op, addr, wd, ed, ee, el, elo, eoe);
      run_cmd(op, addr, wd, hold, d, e, l, lo, oe, acc);
      chk({nm, "_data"},  32'(d), 32'(ed));
      chk({nm, "_err"},   32'(e), 32'(ee));
      chk({nm, "_lat"},   32'(l), 32'(el));
      chk({nm, "_loads"}, 32'(lo), 32'(elo));
      chk({nm, "_oes"},   32'(oe), 32'(eoe));
   endtask

   typedef struct {
      logic [1:0]    op;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      int            hold;
      logic [DW-1:0] exp_data;
      logic          exp_err;
      int            exp_lat;
   } vec_t;

   // global time bound
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[10];
      logic [DW-1:0] d;
      logic e;
      int l, n, a0, a1, a2, a3, a4;
      int r;
      logic [1:0] op;

      vt[0] = '{2'b01, 4'd3,  8'hA5, 0, 8'h00, 1'b0, 2};
      vt[1] = '{2'b00, 4'd3,  8'h00, 0, 8'hA5, 1'b0, 3};
      vt[2] = '{2'b10, 4'd9,  8'h3C, 0, 8'h00, 1'b0, 17};
      vt[3] = '{2'b00, 4'd0,  8'h00, 0, 8'h3C, 1'b0, 3};
      vt[4] = '{2'b00, 4'd7,  8'h00, 0, 8'h3C, 1'b0, 3};
      vt[5] = '{2'b00, 4'd15, 8'h00, 0, 8'h3C, 1'b0, 3};
      vt[6] = '{2'b00, 4'd3,  8'h00, 5, 8'h3C, 1'b0, 3};
      vt[7] = '{2'b11, 4'd2,  8'hFF, 0, 8'h00, 1'b1, 1};
      vt[8] = '{2'b01, 4'd15, 8'h5A, 2, 8'h00, 1'b0, 2};
      vt[9] = '{2'b00, 4'd15, 8'h00, 0, 8'h5A, 1'b0, 3};

      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);

      // reset and release
      rst_n = 1'b0; ram_init = 1'b1;
      cmd_valid_i = 1'b0; cmd_op_i = 2'b00; cmd_addr_i = '0; cmd_wdata_i = '0;
      rsp_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      ram_init = 1'b0;
      chk_all_zero("rst");
      rst_n = 1'b1;
      #1 chk("rel_ready_before_edge", 32'(cmd_ready_o), 0);
      @(negedge clk);
      chk("rel_ready_after_edge", 32'(cmd_ready_o), 1);

      // directed vector table
      for (int i = 0; i < 10; i++) begin
         exec(vt[i].op, vt[i].addr, vt[i].wd, vt[i].hold, "tbl", d, e, l, a0);
         chk("tbl_vec_data", 32'(d), 32'(vt[i].exp_data));
         chk("tbl_vec_err",  32'(e), 32'(vt[i].exp_err));
         chk("tbl_vec_lat",  32'(l), 32'(vt[i].exp_lat));
      end

      // back-to-back spacing with rsp_ready answered immediately
      exec(2'b01, 4'd1, 8'h11, 0, "b2b", d, e, l, a0);
      exec(2'b01, 4'd2, 8'h22, 0, "b2b", d, e, l, a1);
      exec(2'b00, 4'd1, 8'h00, 0, "b2b", d, e, l, a2);
      exec(2'b00, 4'd2, 8'h00, 0, "b2b", d, e, l, a3);
      exec(2'b00, 4'd3, 8'h00, 0, "b2b", d, e, l, a4);
      chk("b2b_wr_period", 32'(a1 - a0), 4);
      chk("b2b_wr_to_rd",  32'(a2 - a1), 4);
      chk("b2b_rd_period", 32'(a3 - a2), 5);
      chk("b2b_rd_period2", 32'(a4 - a3), 5);

      // asynchronous reset in the middle of a cycle while idle with state held
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("midrst_ready_before_edge", 32'(cmd_ready_o), 0);
      @(negedge clk);
      chk("midrst_ready_after_edge", 32'(cmd_ready_o), 1);

      // reset while a fill is writing address 5
      cmd_valid_i = 1'b1; cmd_op_i = 2'b10; cmd_addr_i = 4'd0; cmd_wdata_i = 8'h77;
      @(posedge clk);
      @(negedge clk);
      cmd_valid_i = 1'b0;
      n = 0;
      while (!(mem_load_o === 1'b1 && mem_addr_o === 4'd5) && n < 40) begin @(negedge clk); n++; end
      chk("abort_reached_5", 32'(mem_addr_o), 5);
      #2 rst_n = 1'b0;
      #1 begin
         chk("abort_load_drop", 32'(mem_load_o), 0);
         chk_all_zero("abort");
      end
      for (int i = 0; i < 5; i++) ref_mem[i] = 8'h77;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("abort_no_rsp", 32'(rsp_valid_o), 0);
      end
      for (int i = 0; i < DEPTH; i++) exec(2'b00, AW'(i), 8'h00, 0, "abort_rd", d, e, l, a0);

      // randomized commands
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         op = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
         exec(op, AW'($urandom), DW'($urandom), $urandom_range(0, 3), "rnd", d, e, l, a0);
      end
      for (int i = 0; i < DEPTH; i++) exec(2'b00, AW'(i), 8'h00, 0, "final_rd", d, e, l, a0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
